// File: rtl/universal_shift_reg.sv
// universal_shift_reg
// WIDTH-bit register with hold, shift-right, shift-left and parallel load.
// Serial and parallel inputs and outputs are provided. A fill counter tracks
// how many valid bits have entered the register, and a one-cycle done pulse
// marks the first time the register becomes full through shifting.
//
// Handshake/timing contract: there is no valid/ready pair. Every rising
// edge with rst=1 is one operation. clr has priority over en/mode. All
// outputs come straight from registers, so there is no combinational path
// from any input to any output.
module universal_shift_reg #(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic [1:0]       mode,
    input  logic             sin_r,
    input  logic             sin_l,
    input  logic [WIDTH-1:0] pin,
    output logic [WIDTH-1:0] pout,
    output logic             sout_r,
    output logic             sout_l,
    output logic [CNT_W-1:0] fill,
    output logic             full,
    output logic             done
);

    typedef enum logic [1:0] {
        MODE_HOLD  = 2'b00,
        MODE_RIGHT = 2'b01,
        MODE_LEFT  = 2'b10,
        MODE_LOAD  = 2'b11
    } mode_e;

    localparam logic [CNT_W-1:0] FILL_MAX = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] FILL_ONE = CNT_W'(1);

    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] q_next;
    logic [CNT_W-1:0] fill_q;
    logic [CNT_W-1:0] fill_next;
    logic             done_q;
    logic             done_next;
    logic             shift_op;

    // Next-state selection: clr beats en/mode; a shift also advances the
    // saturating fill count and decides whether this edge completes the fill.
    always_comb begin
        q_next    = q;
        fill_next = fill_q;
        done_next = 1'b0;
        shift_op  = 1'b0;
        if (clr) begin
            q_next    = '0;
            fill_next = '0;
        end else if (en) begin
            unique case (mode_e'(mode))
                MODE_HOLD: begin
                    q_next = q;
                end
                MODE_RIGHT: begin
                    q_next   = {sin_r, q[WIDTH-1:1]};
                    shift_op = 1'b1;
                end
                MODE_LEFT: begin
                    q_next   = {q[WIDTH-2:0], sin_l};
                    shift_op = 1'b1;
                end
                MODE_LOAD: begin
                    q_next    = pin;
                    fill_next = FILL_MAX;
                end
                default: begin
                    q_next = q;
                end
            endcase
        end
        if (shift_op) begin
            // Only the transition WIDTH-1 -> WIDTH pulses done; shifting
            // while already full keeps the count pinned and stays quiet.
            if (fill_q == FILL_MAX) begin
                fill_next = FILL_MAX;
            end else begin
                fill_next = fill_q + FILL_ONE;
            end
            done_next = (fill_q == (FILL_MAX - FILL_ONE));
        end
    end

    // State register with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q      <= '0;
            fill_q <= '0;
            done_q <= 1'b0;
        end else begin
            q      <= q_next;
            fill_q <= fill_next;
            done_q <= done_next;
        end
    end

    assign pout   = q;
    assign sout_r = q[0];
    assign sout_l = q[WIDTH-1];
    assign fill   = fill_q;
    assign full   = (fill_q == FILL_MAX);
    assign done   = done_q;

endmodule

// File: tb/tb_universal_shift_reg.sv
// Bench for universal_shift_reg: three instances (WIDTH 2, 4, 8) share one
// input stream. A driver applies operations and pushes the expected outputs
// of all three into a queue; a monitor pops and compares after each rising
// edge and after each asynchronous reset assertion.
module tb_universal_shift_reg;

    typedef struct packed {
        logic [63:0] pout;
        logic [6:0]  fill;
        logic        full;
        logic        done;
        logic        sr;
        logic        sl;
    } obs_t;

    typedef obs_t [2:0] trio_t;

    int wid [3] = '{2, 4, 8};

    logic       clk;
    logic       rst;
    logic       en;
    logic       clr;
    logic [1:0] mode;
    logic       sin_r;
    logic       sin_l;
    logic [7:0] pin;

    logic [1:0] pout2;
    logic [3:0] pout4;
    logic [7:0] pout8;
    logic       sr2, sr4, sr8, sl2, sl4, sl8;
    logic [1:0] fill2;
    logic [2:0] fill4;
    logic [3:0] fill8;
    logic       full2, full4, full8, done2, done4, done8;

    int checks = 0;
    int errors = 0;

    trio_t exp_q[$];

    // Reference model state: register value as a number, fill as a count.
    logic [63:0] m_q    [3];
    int          m_fill [3];
    logic        m_done [3];

    universal_shift_reg #(.WIDTH(2)) dut2 (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .mode(mode),
        .sin_r(sin_r), .sin_l(sin_l), .pin(pin[1:0]),
        .pout(pout2), .sout_r(sr2), .sout_l(sl2),
        .fill(fill2), .full(full2), .done(done2)
    );

    universal_shift_reg #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .mode(mode),
        .sin_r(sin_r), .sin_l(sin_l), .pin(pin[3:0]),
        .pout(pout4), .sout_r(sr4), .sout_l(sl4),
        .fill(fill4), .full(full4), .done(done4)
    );

    universal_shift_reg #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .mode(mode),
        .sin_r(sin_r), .sin_l(sin_l), .pin(pin),
        .pout(pout8), .sout_r(sr8), .sout_l(sl8),
        .fill(fill8), .full(full8), .done(done8)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- model ----------------
    function automatic trio_t model_obs();
        trio_t t;
        for (int i = 0; i < 3; i++) begin
            t[i].pout = m_q[i];
            t[i].fill = 7'(m_fill[i]);
            t[i].full = (m_fill[i] == wid[i]);
            t[i].done = m_done[i];
            t[i].sr   = m_q[i][0];
            t[i].sl   = m_q[i][wid[i]-1];
        end
        return t;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_q[i]    = '0;
            m_fill[i] = 0;
            m_done[i] = 1'b0;
        end
    endtask

    task automatic model_step();
        for (int i = 0; i < 3; i++) begin
            int          w;
            logic [63:0] mask;
            bit          shifted;
            w       = wid[i];
            mask    = (64'd1 << w) - 64'd1;
            shifted = 1'b0;
            m_done[i] = 1'b0;
            if (clr) begin
                m_q[i]    = '0;
                m_fill[i] = 0;
            end else if (en) begin
                if (mode == 2'd1) begin
                    m_q[i]  = (m_q[i] >> 1) | (64'(sin_r) << (w - 1));
                    shifted = 1'b1;
                end else if (mode == 2'd2) begin
                    m_q[i]  = ((m_q[i] << 1) | 64'(sin_l)) & mask;
                    shifted = 1'b1;
                end else if (mode == 2'd3) begin
                    m_q[i]    = 64'(pin) & mask;
                    m_fill[i] = w;
                end
            end
            if (shifted) begin
                m_done[i] = (m_fill[i] == w - 1);
                if (m_fill[i] < w) m_fill[i] = m_fill[i] + 1;
            end
        end
    endtask

    // ---------------- driver ----------------
    task automatic apply(input logic e, input logic c, input logic [1:0] m,
                         input logic r, input logic l, input logic [7:0] p);
        en    = e;
        clr   = c;
        mode  = m;
        sin_r = r;
        sin_l = l;
        pin   = p;
        model_step();
        exp_q.push_back(model_obs());
    endtask

    task automatic cycle(input logic e, input logic c, input logic [1:0] m,
                         input logic r, input logic l, input logic [7:0] p);
        @(negedge clk);
        apply(e, c, m, r, l, p);
    endtask

    // Assert reset in the low phase, between edges, then release it before
    // the next rising edge with an idle operation queued.
    task automatic async_reset_pulse();
        @(negedge clk);
        #1;
        model_reset();
        exp_q.push_back(model_obs());
        rst = 1'b0;
        #2;
        rst = 1'b1;
        apply(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 8'h00);
    endtask

    // ---------------- scoreboard / monitor ----------------
    task automatic check_field(input string name, input int inst,
                               input logic [63:0] act, input logic [63:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s w=%0d actual=%0h expected=%0h at %0t",
                     name, wid[inst], act, exp_v, $time);
        end
    endtask

    function automatic trio_t dut_obs();
        trio_t t;
        t[0] = '{pout: 64'(pout2), fill: 7'(fill2), full: full2, done: done2, sr: sr2, sl: sl2};
        t[1] = '{pout: 64'(pout4), fill: 7'(fill4), full: full4, done: done4, sr: sr4, sl: sl4};
        t[2] = '{pout: 64'(pout8), fill: 7'(fill8), full: full8, done: done8, sr: sr8, sl: sl8};
        return t;
    endfunction

    initial begin
        trio_t e;
        trio_t a;
        forever begin
            @(posedge clk or negedge rst);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = dut_obs();
                for (int i = 0; i < 3; i++) begin
                    check_field("pout",   i, a[i].pout,       e[i].pout);
                    check_field("fill",   i, 64'(a[i].fill),  64'(e[i].fill));
                    check_field("full",   i, 64'(a[i].full),  64'(e[i].full));
                    check_field("done",   i, 64'(a[i].done),  64'(e[i].done));
                    check_field("sout_r", i, 64'(a[i].sr),    64'(e[i].sr));
                    check_field("sout_l", i, 64'(a[i].sl),    64'(e[i].sl));
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [3:0] bits_r;
        rst   = 1'b1;
        en    = 1'b0;
        clr   = 1'b0;
        mode  = 2'd0;
        sin_r = 1'b0;
        sin_l = 1'b0;
        pin   = 8'h00;
        #3;
        model_reset();
        exp_q.push_back(model_obs());
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // Preload 1011 (low nibble) then pulse reset between edges.
        cycle(1'b1, 1'b0, 2'd3, 1'b0, 1'b0, 8'h5B);
        async_reset_pulse();

        // Serial right 1,0,0,1 then a fifth shift.
        bits_r = 4'b1001;
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 2'd1, bits_r[3-i], 1'b0, 8'h00);
        cycle(1'b1, 1'b0, 2'd1, 1'b0, 1'b0, 8'h00);

        // Load A5 then drain with eight right shifts of 0.
        cycle(1'b1, 1'b0, 2'd3, 1'b0, 1'b0, 8'hA5);
        for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 2'd1, 1'b0, 1'b0, 8'h00);

        // Clear, then left, left, right (direction change).
        cycle(1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 8'h00);
        cycle(1'b1, 1'b0, 2'd2, 1'b0, 1'b1, 8'h00);
        cycle(1'b1, 1'b0, 2'd2, 1'b0, 1'b1, 8'h00);
        cycle(1'b1, 1'b0, 2'd1, 1'b0, 1'b0, 8'h00);

        // clr beats an enabled shift; then en=0 with a load request holds.
        cycle(1'b1, 1'b1, 2'd1, 1'b1, 1'b0, 8'h00);
        cycle(1'b0, 1'b0, 2'd3, 1'b0, 1'b0, 8'hFF);
        // clr and load on the same edge.
        cycle(1'b1, 1'b0, 2'd3, 1'b0, 1'b0, 8'h3C);
        cycle(1'b1, 1'b1, 2'd3, 1'b0, 1'b0, 8'hFF);

        // Alternate left/right for saturation and single done pulse.
        for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, (i % 2 == 0) ? 2'd2 : 2'd1, 1'b1, 1'b0, 8'h00);

        // Randomized traffic with occasional clears and async resets.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 63) == 0) begin
                async_reset_pulse();
            end else begin
                cycle(($urandom_range(0, 3) != 0),
                      ($urandom_range(0, 15) == 0),
                      2'($urandom_range(0, 3)),
                      1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)),
                      8'($urandom_range(0, 255)));
            end
        end

        @(posedge clk);
        #3;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL queue_drain actual=%0d expected=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
